// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- memory-access pipeline stage (EXE -> MEM -> WB)
//
// Purpose:
//   Latches the EXE->MEM bus. Picks up the synchronous data-SRAM read data one
//   cycle after EXE issued the request, then aligns and sign/zero-extends the
//   load result. Drives the forward bus to decode and an exception-pending flag
//   back to EXE. A one-entry read-data buffer keeps the SRAM data of a stalled
//   load, because the SRAM output is only guaranteed for one cycle.
//
// Ports:
//   clk             in   single clock, all state on posedge
//   resetn          in   asynchronous active-low reset
//   ws_allowin      in   WB can accept this cycle
//   ms_allowin      out  MEM can accept this cycle
//   es_to_ms_valid  in   EXE offers an instruction
//   es_to_ms_bus    in   {vaddr,esubcode,ex,ertn,csr_wvalue,ecode,csr_re,csr_we,
//                         csr_num,csr_wmask,load_op,res_from_mem,gr_we,dest,result,pc}
//   ms_to_ws_valid  out  MEM offers an instruction to WB
//   ms_to_ws_bus    out  same order, without load_op/res_from_mem, with
//                        final_result in place of result
//   ms_fwd_bus      out  {csr_re&&valid, gr_we&&valid, dest, final_result}
//   data_sram_rdata in   SRAM read data (valid in the first MEM cycle)
//   ms_flush_pipe   in   flush from WB (exception or ertn commit)
//   ms_ex           out  valid instruction in MEM carries an exception
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 205,
    parameter int MS_TO_WS_BUS_WD = 199,
    parameter int MS_FWD_BUS_WD   = 39
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       ms_flush_pipe,
    output logic                       ms_ex
);

    typedef enum logic [0:0] {
        RBUF_EMPTY = 1'b0,
        RBUF_HELD  = 1'b1
    } rbuf_state_e;

    // Pipeline and buffer state
    logic                       ms_valid_q;
    logic                       ms_valid_d;
    logic [ES_TO_MS_BUS_WD-1:0] es_bus_q;
    logic [ES_TO_MS_BUS_WD-1:0] es_bus_d;
    rbuf_state_e                rbuf_state_q;
    rbuf_state_e                rbuf_state_d;
    logic [31:0]                rbuf_q;
    logic [31:0]                rbuf_d;

    // Decoded fields of the latched bus
    logic [31:0]  vaddr_s;
    logic         ex_s;
    logic         csr_re_s;
    logic [4:0]   load_op_s;
    logic         res_from_mem_s;
    logic         gr_we_s;
    logic [4:0]   dest_s;
    logic [31:0]  result_s;
    logic [31:0]  pc_s;
    logic [128:0] ws_head_s;

    logic         ms_ready_go_s;
    logic [31:0]  rdata_s;
    logic [7:0]   ld_byte_s;
    logic [15:0]  ld_half_s;
    logic [31:0]  ld_value_s;
    logic [31:0]  final_result_s;

    assign vaddr_s        = es_bus_q[204:173];
    assign ex_s           = es_bus_q[163];
    assign csr_re_s       = es_bus_q[123];
    assign load_op_s      = es_bus_q[75:71];
    assign res_from_mem_s = es_bus_q[70];
    assign gr_we_s        = es_bus_q[69];
    assign dest_s         = es_bus_q[68:64];
    assign result_s       = es_bus_q[63:32];
    assign pc_s           = es_bus_q[31:0];
    // vaddr down to csr_wmask passes to WB unchanged
    assign ws_head_s      = es_bus_q[204:76];

    // SRAM has a fixed one-cycle latency, so MEM never waits on memory
    assign ms_ready_go_s  = 1'b1;
    assign ms_allowin     = !ms_valid_q || (ms_ready_go_s && ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go_s && !ms_flush_pipe;
    assign ms_ex          = ms_valid_q && ex_s;

    // Pipeline valid: flush kills the slot regardless of backpressure
    always_comb begin
        ms_valid_d = ms_valid_q;
        if (ms_flush_pipe) begin
            ms_valid_d = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end else begin
            ms_valid_d = ms_valid_q;
        end
    end

    // Bus register loads whenever an offer is accepted
    always_comb begin
        es_bus_d = es_bus_q;
        if (es_to_ms_valid && ms_allowin) begin
            es_bus_d = es_to_ms_bus;
        end else begin
            es_bus_d = es_bus_q;
        end
    end

    // Read-data buffer next state: capture SRAM data on the first stalled load cycle
    always_comb begin
        rbuf_state_d = rbuf_state_q;
        rbuf_d       = rbuf_q;
        case (rbuf_state_q)
            RBUF_EMPTY: begin
                if (!ms_flush_pipe && ms_valid_q && res_from_mem_s && !ms_allowin) begin
                    rbuf_state_d = RBUF_HELD;
                    rbuf_d       = data_sram_rdata;
                end else begin
                    rbuf_state_d = RBUF_EMPTY;
                end
            end
            RBUF_HELD: begin
                if (ms_flush_pipe) begin
                    rbuf_state_d = RBUF_EMPTY;
                    rbuf_d       = 32'h0000_0000;
                end else if (ms_allowin) begin
                    rbuf_state_d = RBUF_EMPTY;
                end else begin
                    rbuf_state_d = RBUF_HELD;
                end
            end
            default: begin
                rbuf_state_d = RBUF_EMPTY;
                rbuf_d       = 32'h0000_0000;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_q   <= 1'b0;
            es_bus_q     <= '0;
            rbuf_state_q <= RBUF_EMPTY;
            rbuf_q       <= 32'h0000_0000;
        end else begin
            ms_valid_q   <= ms_valid_d;
            es_bus_q     <= es_bus_d;
            rbuf_state_q <= rbuf_state_d;
            rbuf_q       <= rbuf_d;
        end
    end

    // Once buffered, the load must use the held copy: the SRAM output may have moved on
    assign rdata_s = (rbuf_state_q == RBUF_HELD) ? rbuf_q : data_sram_rdata;

    // Byte lane select by address offset
    always_comb begin
        ld_byte_s = 8'h00;
        case (vaddr_s[1:0])
            2'd0:    ld_byte_s = rdata_s[7:0];
            2'd1:    ld_byte_s = rdata_s[15:8];
            2'd2:    ld_byte_s = rdata_s[23:16];
            2'd3:    ld_byte_s = rdata_s[31:24];
            default: ld_byte_s = 8'h00;
        endcase
    end

    // Half lane select by address bit 1
    always_comb begin
        ld_half_s = 16'h0000;
        if (vaddr_s[1]) begin
            ld_half_s = rdata_s[31:16];
        end else begin
            ld_half_s = rdata_s[15:0];
        end
    end

    // Load extension by one-hot load_op
    always_comb begin
        ld_value_s = rdata_s;
        case (load_op_s)
            5'b00001: ld_value_s = {{24{ld_byte_s[7]}}, ld_byte_s};
            5'b01000: ld_value_s = {24'h000000, ld_byte_s};
            5'b00010: ld_value_s = {{16{ld_half_s[15]}}, ld_half_s};
            5'b10000: ld_value_s = {16'h0000, ld_half_s};
            5'b00100: ld_value_s = rdata_s;
            default:  ld_value_s = rdata_s;
        endcase
    end

    // An excepting instruction (e.g. misaligned load) keeps the EXE result
    always_comb begin
        final_result_s = result_s;
        if (!ex_s && res_from_mem_s) begin
            final_result_s = ld_value_s;
        end else begin
            final_result_s = result_s;
        end
    end

    assign ms_to_ws_bus = {ws_head_s, gr_we_s, dest_s, final_result_s, pc_s};
    assign ms_fwd_bus   = {csr_re_s && ms_valid_q, ms_valid_q && gr_we_s, dest_s, final_result_s};

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    typedef struct packed {
        logic [31:0] vaddr;
        logic [8:0]  esubcode;
        logic        ex;
        logic        ertn;
        logic [31:0] csr_wvalue;
        logic [5:0]  ecode;
        logic        csr_re;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [4:0]  load_op;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } es_t;

    typedef struct packed {
        logic [31:0] vaddr;
        logic [8:0]  esubcode;
        logic        ex;
        logic        ertn;
        logic [31:0] csr_wvalue;
        logic [5:0]  ecode;
        logic        csr_re;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ws_t;

    localparam logic [4:0] OP_B  = 5'b00001;
    localparam logic [4:0] OP_H  = 5'b00010;
    localparam logic [4:0] OP_W  = 5'b00100;
    localparam logic [4:0] OP_BU = 5'b01000;
    localparam logic [4:0] OP_HU = 5'b10000;

    logic         clk;
    logic         resetn;
    logic         ws_allowin;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [204:0] es_to_ms_bus;
    logic         ms_to_ws_valid;
    logic [198:0] ms_to_ws_bus;
    logic [38:0]  ms_fwd_bus;
    logic [31:0]  data_sram_rdata;
    logic         ms_flush_pipe;
    logic         ms_ex;

    mem_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .ms_fwd_bus      (ms_fwd_bus),
        .data_sram_rdata (data_sram_rdata),
        .ms_flush_pipe   (ms_flush_pipe),
        .ms_ex           (ms_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: which instruction sits in MEM and the data its load saw
    logic        m_valid;
    logic        m_first;
    es_t         m_bus;
    logic [31:0] m_ldata;
    // Inputs applied this cycle
    logic        d_v, d_ws, d_fl;
    es_t         d_b;
    // Expected outputs for this cycle
    logic        exp_allowin, exp_tws, exp_ex;
    logic [1:0]  exp_fwd_hi;
    logic [31:0] exp_fr;
    ws_t         exp_ws;
    ws_t         obs_ws;

    function automatic logic [31:0] ld_ext(input logic [4:0] op, input logic [1:0] off,
                                           input logic [31:0] w);
        logic [31:0] v;
        logic [31:0] b;
        logic [31:0] h;
        v = w >> (8 * off);
        b = v % 32'd256;
        h = v % 32'd65536;
        case (op)
            OP_B:    return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
            OP_BU:   return b;
            OP_H:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            OP_HU:   return h;
            OP_W:    return w;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic es_t gen_instr();
        es_t         e;
        int unsigned k;
        e.vaddr        = $urandom();
        e.esubcode     = 9'($urandom());
        e.ex           = ($urandom_range(0, 7) == 0);
        e.ertn         = 1'($urandom());
        e.csr_wvalue   = $urandom();
        e.ecode        = 6'($urandom());
        e.csr_re       = 1'($urandom());
        e.csr_we       = 1'($urandom());
        e.csr_num      = 14'($urandom());
        e.csr_wmask    = $urandom();
        e.res_from_mem = 1'($urandom());
        e.gr_we        = 1'($urandom());
        e.dest         = 5'($urandom());
        e.result       = $urandom();
        e.pc           = $urandom();
        k              = $urandom_range(0, 4);
        e.load_op      = 5'(1 << k);
        if (!e.ex) begin
            if (e.load_op == OP_W) begin
                e.vaddr[1:0] = 2'd0;
            end else if (e.load_op == OP_H || e.load_op == OP_HU) begin
                e.vaddr[1:0] = {1'($urandom()), 1'b0};
            end
        end
        return e;
    endfunction

    function automatic es_t mk_load(input logic [4:0] op, input logic [31:0] va,
                                    input logic [31:0] res);
        es_t e;
        e              = '0;
        e.vaddr        = va;
        e.load_op      = op;
        e.res_from_mem = 1'b1;
        e.gr_we        = 1'b1;
        e.dest         = 5'd4;
        e.result       = res;
        e.pc           = 32'h1C00_0000 + va;
        return e;
    endfunction

    // Apply this cycle's inputs and derive expected outputs from the model
    task automatic drive(input logic v, input es_t b, input logic ws, input logic fl,
                         input logic [31:0] rd);
        d_v = v; d_b = b; d_ws = ws; d_fl = fl;
        es_to_ms_valid  = v;
        es_to_ms_bus    = b;
        ws_allowin      = ws;
        ms_flush_pipe   = fl;
        data_sram_rdata = rd;
        if (m_valid && m_first) m_ldata = rd;
        #1;
        exp_allowin = !m_valid || ws;
        exp_tws     = m_valid && !fl;
        exp_ex      = m_valid && m_bus.ex;
        if (!m_bus.ex && m_bus.res_from_mem)
            exp_fr = ld_ext(m_bus.load_op, m_bus.vaddr[1:0], m_ldata);
        else
            exp_fr = m_bus.result;
        exp_fwd_hi = {m_bus.csr_re && m_valid, m_valid && m_bus.gr_we};
        exp_ws = '{vaddr: m_bus.vaddr, esubcode: m_bus.esubcode, ex: m_bus.ex,
                   ertn: m_bus.ertn, csr_wvalue: m_bus.csr_wvalue, ecode: m_bus.ecode,
                   csr_re: m_bus.csr_re, csr_we: m_bus.csr_we, csr_num: m_bus.csr_num,
                   csr_wmask: m_bus.csr_wmask, gr_we: m_bus.gr_we, dest: m_bus.dest,
                   final_result: exp_fr, pc: m_bus.pc};
        obs_ws = ms_to_ws_bus;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_first = 1'b0;
        m_bus   = '0;
        m_ldata = 32'h0;
    endtask

    // Clock edge: advance the model with the inputs applied this cycle
    task automatic advance();
        logic allow;
        @(posedge clk);
        if (!resetn) begin
            model_reset();
        end else begin
            allow   = !m_valid || d_ws;
            m_first = 1'b0;
            if (d_v && allow) m_bus = d_b;
            if (d_fl) begin
                m_valid = 1'b0;
            end else if (allow) begin
                m_valid = d_v;
                m_first = d_v;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        model_reset();
        drive(1'b0, '0, 1'b1, 1'b0, 32'hA5A5_5A5A);
        n_checks++; if (ms_allowin !== 1'b1) begin n_fail++; $display("FAIL reset_allowin: got %b want 1", ms_allowin); end
        n_checks++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tws_valid: got %b want 0", ms_to_ws_valid); end
        n_checks++; if (ms_ex !== 1'b0) begin n_fail++; $display("FAIL reset_ms_ex: got %b want 0", ms_ex); end
        n_checks++; if (ms_fwd_bus[38:37] !== 2'b00) begin n_fail++; $display("FAIL reset_fwd_valid: got %b want 00", ms_fwd_bus[38:37]); end
        n_checks++; if (ms_to_ws_bus !== 199'd0) begin n_fail++; $display("FAIL reset_ws_bus: got %h want 0", ms_to_ws_bus); end
        advance();
        resetn = 1'b1;
    endtask

    task automatic test_ld_w();
        drive(1'b1, mk_load(OP_W, 32'h0000_1000, 32'h0000_1000), 1'b1, 1'b0, 32'h0);
        n_checks++; if (ms_allowin !== 1'b1) begin n_fail++; $display("FAIL ldw_accept: got %b want 1", ms_allowin); end
        advance();
        drive(1'b0, '0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        n_checks++; if (ms_to_ws_valid !== 1'b1) begin n_fail++; $display("FAIL ldw_valid: got %b want 1", ms_to_ws_valid); end
        n_checks++; if (obs_ws.final_result !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ldw_result: got %h want deadbeef", obs_ws.final_result); end
        n_checks++; if (ms_to_ws_bus !== exp_ws) begin n_fail++; $display("FAIL ldw_bus: got %h want %h", ms_to_ws_bus, exp_ws); end
        advance();
    endtask

    task automatic test_ld_ext();
        logic [4:0]  ops  [3] = '{OP_B, OP_BU, OP_HU};
        logic [31:0] vas  [3] = '{32'h0000_2003, 32'h0000_2003, 32'h0000_2002};
        logic [31:0] want [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_8011};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, mk_load(ops[i], vas[i], 32'h5555_5555), 1'b1, 1'b0, 32'h0);
            advance();
            drive(1'b0, '0, 1'b1, 1'b0, 32'h8011_2233);
            n_checks++; if (obs_ws.final_result !== want[i]) begin n_fail++; $display("FAIL ld_ext[%0d]: got %h want %h", i, obs_ws.final_result, want[i]); end
            n_checks++; if (ms_fwd_bus[31:0] !== want[i]) begin n_fail++; $display("FAIL ld_ext_fwd[%0d]: got %h want %h", i, ms_fwd_bus[31:0], want[i]); end
            advance();
        end
    endtask

    task automatic test_stall_ld_h();
        drive(1'b1, mk_load(OP_H, 32'h0000_3000, 32'h0), 1'b1, 1'b0, 32'h0);
        advance();
        drive(1'b0, '0, 1'b0, 1'b0, 32'h1234_ABCD);
        n_checks++; if (ms_allowin !== 1'b0) begin n_fail++; $display("FAIL stall_allowin0: got %b want 0", ms_allowin); end
        advance();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, gen_instr(), 1'b0, 1'b0, 32'h0000_0000);
            n_checks++; if (obs_ws.final_result !== 32'hFFFF_ABCD) begin n_fail++; $display("FAIL stall_hold[%0d]: got %h want ffffabcd", i, obs_ws.final_result); end
            n_checks++; if (ms_allowin !== 1'b0) begin n_fail++; $display("FAIL stall_allowin[%0d]: got %b want 0", i, ms_allowin); end
            advance();
        end
        drive(1'b0, '0, 1'b1, 1'b0, 32'h0000_0000);
        n_checks++; if (ms_to_ws_valid !== 1'b1) begin n_fail++; $display("FAIL stall_release_valid: got %b want 1", ms_to_ws_valid); end
        n_checks++; if (obs_ws.final_result !== 32'hFFFF_ABCD) begin n_fail++; $display("FAIL stall_release: got %h want ffffabcd", obs_ws.final_result); end
        advance();
    endtask

    task automatic test_flush();
        es_t a;
        a = '0; a.result = 32'h7; a.gr_we = 1'b1; a.dest = 5'd9; a.pc = 32'h1C00_0100;
        drive(1'b1, a, 1'b1, 1'b0, 32'h0);
        advance();
        // flush together with a new offer: the offer must be dropped
        drive(1'b1, gen_instr(), 1'b1, 1'b1, 32'h0);
        n_checks++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL flush_tws_valid: got %b want 0", ms_to_ws_valid); end
        n_checks++; if (ms_fwd_bus[31:0] !== 32'h7) begin n_fail++; $display("FAIL flush_fwd_result: got %h want 7", ms_fwd_bus[31:0]); end
        advance();
        drive(1'b0, '0, 1'b1, 1'b0, 32'h0);
        n_checks++; if (ms_fwd_bus[37] !== 1'b0) begin n_fail++; $display("FAIL flush_killed: got %b want 0", ms_fwd_bus[37]); end
        n_checks++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop_offer: got %b want 0", ms_to_ws_valid); end
        advance();
        // stall then flush with the buffer held, then a fresh load
        drive(1'b1, mk_load(OP_W, 32'h0000_4000, 32'h0), 1'b1, 1'b0, 32'h0);
        advance();
        drive(1'b0, '0, 1'b0, 1'b0, 32'h1111_1111);
        advance();
        drive(1'b0, '0, 1'b0, 1'b1, 32'h2222_2222);
        n_checks++; if (obs_ws.final_result !== 32'h1111_1111) begin n_fail++; $display("FAIL flush_held_data: got %h want 11111111", obs_ws.final_result); end
        advance();
        drive(1'b1, mk_load(OP_W, 32'h0000_4004, 32'h0), 1'b0, 1'b0, 32'h0);
        n_checks++; if (ms_allowin !== 1'b1) begin n_fail++; $display("FAIL flush_allowin: got %b want 1", ms_allowin); end
        advance();
        drive(1'b0, '0, 1'b0, 1'b0, 32'h3333_3333);
        n_checks++; if (obs_ws.final_result !== 32'h3333_3333) begin n_fail++; $display("FAIL flush_fresh_load: got %h want 33333333", obs_ws.final_result); end
        advance();
        drive(1'b0, '0, 1'b1, 1'b0, 32'h4444_4444);
        n_checks++; if (obs_ws.final_result !== exp_fr) begin n_fail++; $display("FAIL flush_fresh_held: got %h want %h", obs_ws.final_result, exp_fr); end
        advance();
    endtask

    task automatic test_ex();
        es_t e;
        e = mk_load(OP_W, 32'h0000_5001, 32'h0000_5001);
        e.ex = 1'b1; e.ecode = 6'h09;
        drive(1'b1, e, 1'b1, 1'b0, 32'h0);
        advance();
        drive(1'b0, '0, 1'b1, 1'b0, 32'hCAFE_F00D);
        n_checks++; if (ms_ex !== 1'b1) begin n_fail++; $display("FAIL ex_flag: got %b want 1", ms_ex); end
        n_checks++; if (obs_ws.ex !== 1'b1 || obs_ws.ecode !== 6'h09) begin n_fail++; $display("FAIL ex_bus: got ex=%b ecode=%h want 1/09", obs_ws.ex, obs_ws.ecode); end
        n_checks++; if (obs_ws.final_result !== 32'h0000_5001) begin n_fail++; $display("FAIL ex_result: got %h want 00005001", obs_ws.final_result); end
        advance();
        drive(1'b0, '0, 1'b1, 1'b0, 32'h0);
        n_checks++; if (ms_ex !== 1'b0) begin n_fail++; $display("FAIL ex_clear: got %b want 0", ms_ex); end
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, gen_instr(), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0, $urandom());
            n_checks++; if (ms_allowin !== exp_allowin) begin n_fail++; $display("FAIL rnd_allowin@%0d: got %b want %b", i, ms_allowin, exp_allowin); end
            n_checks++; if (ms_to_ws_valid !== exp_tws) begin n_fail++; $display("FAIL rnd_tws_valid@%0d: got %b want %b", i, ms_to_ws_valid, exp_tws); end
            n_checks++; if (ms_ex !== exp_ex) begin n_fail++; $display("FAIL rnd_ex@%0d: got %b want %b", i, ms_ex, exp_ex); end
            n_checks++; if (ms_fwd_bus[38:37] !== exp_fwd_hi) begin n_fail++; $display("FAIL rnd_fwd_valid@%0d: got %b want %b", i, ms_fwd_bus[38:37], exp_fwd_hi); end
            if (m_valid) begin
                n_checks++; if (ms_to_ws_bus !== exp_ws) begin n_fail++; $display("FAIL rnd_ws_bus@%0d: got %h want %h", i, ms_to_ws_bus, exp_ws); end
                n_checks++; if (ms_fwd_bus[36:0] !== {m_bus.dest, exp_fr}) begin n_fail++; $display("FAIL rnd_fwd@%0d: got %h want %h", i, ms_fwd_bus[36:0], {m_bus.dest, exp_fr}); end
            end
            advance();
        end
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, mk_load(OP_W, 32'h0000_6000, 32'h0), 1'b1, 1'b0, 32'h0);
        advance();
        drive(1'b0, '0, 1'b0, 1'b0, 32'h5A5A_0001);
        advance();
        drive(1'b0, '0, 1'b0, 1'b0, 32'h0);
        resetn = 1'b0;
        #1;
        model_reset();
        n_checks++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL areset_tws_valid: got %b want 0", ms_to_ws_valid); end
        n_checks++; if (ms_allowin !== 1'b1) begin n_fail++; $display("FAIL areset_allowin: got %b want 1", ms_allowin); end
        n_checks++; if (ms_fwd_bus[38:37] !== 2'b00) begin n_fail++; $display("FAIL areset_fwd_valid: got %b want 00", ms_fwd_bus[38:37]); end
        advance();
        resetn = 1'b1;
        // A fresh stalled load must use its own data, not the pre-reset buffer
        drive(1'b1, mk_load(OP_W, 32'h0000_6004, 32'h0), 1'b1, 1'b0, 32'h0);
        advance();
        drive(1'b0, '0, 1'b1, 1'b0, 32'h0BAD_F00D);
        n_checks++; if (obs_ws.final_result !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL areset_fresh_load: got %h want 0badf00d", obs_ws.final_result); end
        advance();
    endtask

    initial begin
        resetn          = 1'b0;
        es_to_ms_valid  = 1'b0;
        es_to_ms_bus    = '0;
        ws_allowin      = 1'b1;
        ms_flush_pipe   = 1'b0;
        data_sram_rdata = 32'h0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_ld_w();
        test_ld_ext();
        test_stall_ld_h();
        test_flush();
        test_ex();
        test_random();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
